// File: rtl/dsp_nco_phase_acc.sv
// NCO phase accumulator feeding the quarter-wave sine ROM address port.
// Holds the tuning and offset words, advances the phase on enabled cycles,
// and optionally sweeps the tuning word linearly toward an end value.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FIX   | fixed tuning word, no sweep activity
// ST_SWEEP | tuning word steps by step_a each enabled cycle toward end_a
// ST_HOLD  | sweep finished, tuning word parked at end_a
module dsp_nco_phase_acc #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   phase_clr,
    input  logic                   cfg_load,
    input  logic                   cfg_mode,
    input  logic [PHASE_WIDTH-1:0] cfg_ftw,
    input  logic [PHASE_WIDTH-1:0] cfg_ftw_end,
    input  logic [PHASE_WIDTH-1:0] cfg_step,
    input  logic [PHASE_WIDTH-1:0] cfg_pow,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   addr_vld,
    output logic                   busy,
    output logic                   sweep_done
);

    localparam logic [1:0] ST_FIX   = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] ftw_cur;
    logic [PHASE_WIDTH-1:0] pow_a;
    logic [PHASE_WIDTH-1:0] step_a;
    logic [PHASE_WIDTH-1:0] end_a;
    logic                   dir;
    logic [1:0]             state;

    logic [PHASE_WIDTH-1:0] phase_sum;
    logic [ADDR_WIDTH-1:0]  addr_nxt;
    logic [PHASE_WIDTH:0]   sweep_nxt;
    logic                   sweep_reached;
    logic                   cfg_immediate;
    logic                   adv;

    // Phase address and next sweep tuning word; the extra sweep bit catches
    // overshoot past either end of the range instead of letting it wrap.
    always_comb begin
        phase_sum = acc + pow_a;
        addr_nxt  = ADDR_WIDTH'(phase_sum >> (PHASE_WIDTH - ADDR_WIDTH));
        if (dir) begin
            sweep_nxt     = {1'b0, ftw_cur} - {1'b0, step_a};
            sweep_reached = sweep_nxt[PHASE_WIDTH] ||
                            (sweep_nxt[PHASE_WIDTH-1:0] <= end_a);
        end else begin
            sweep_nxt     = {1'b0, ftw_cur} + {1'b0, step_a};
            sweep_reached = (sweep_nxt >= {1'b0, end_a});
        end
    end

    assign cfg_immediate = (cfg_step == '0) || (cfg_ftw == cfg_ftw_end);
    assign adv           = en && !phase_clr;
    assign busy          = (state == ST_SWEEP);

    // Accumulator and registered address output; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            addr     <= '0;
            addr_vld <= 1'b0;
        end else begin
            addr_vld <= adv;
            if (phase_clr) begin
                acc <= '0;
            end else if (en) begin
                acc  <= acc + ftw_cur;
                addr <= addr_nxt;
            end
        end
    end

    // Configuration capture and sweep sequencing; a load always restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_cur    <= '0;
            pow_a      <= '0;
            step_a     <= '0;
            end_a      <= '0;
            dir        <= 1'b0;
            state      <= ST_FIX;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (cfg_load) begin
                pow_a  <= cfg_pow;
                step_a <= cfg_step;
                end_a  <= cfg_ftw_end;
                dir    <= (cfg_ftw_end < cfg_ftw);
                if (!cfg_mode) begin
                    ftw_cur <= cfg_ftw;
                    state   <= ST_FIX;
                end else if (cfg_immediate) begin
                    ftw_cur    <= cfg_ftw_end;
                    state      <= ST_HOLD;
                    sweep_done <= 1'b1;
                end else begin
                    ftw_cur <= cfg_ftw;
                    state   <= ST_SWEEP;
                end
            end else if (state == ST_SWEEP && adv) begin
                if (sweep_reached) begin
                    ftw_cur    <= end_a;
                    state      <= ST_HOLD;
                    sweep_done <= 1'b1;
                end else begin
                    ftw_cur <= sweep_nxt[PHASE_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_nco_phase_acc.sv
// Self-checking bench for dsp_nco_phase_acc: a cycle model predicts each
// edge's outputs into a queue, popped and compared 1 ns after the edge.
module tb_dsp_nco_phase_acc;

    localparam int PW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          phase_clr = 1'b0;
    logic          cfg_load = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [PW-1:0] cfg_ftw = '0;
    logic [PW-1:0] cfg_ftw_end = '0;
    logic [PW-1:0] cfg_step = '0;
    logic [PW-1:0] cfg_pow = '0;
    logic [AW-1:0] addr;
    logic          addr_vld;
    logic          busy;
    logic          sweep_done;

    always #5 clk = ~clk;

    dsp_nco_phase_acc #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
        .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_ftw(cfg_ftw),
        .cfg_ftw_end(cfg_ftw_end), .cfg_step(cfg_step), .cfg_pow(cfg_pow),
        .addr(addr), .addr_vld(addr_vld), .busy(busy), .sweep_done(sweep_done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          vld;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    logic [PW-1:0] m_acc, m_ftw, m_pow, m_step, m_end;
    logic          m_dir, m_vld, m_done;
    logic [AW-1:0] m_addr;
    int            m_state; // 0 fixed, 1 sweeping, 2 holding

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_ftw = '0; m_pow = '0; m_step = '0; m_end = '0;
        m_dir = 1'b0; m_vld = 1'b0; m_done = 1'b0; m_addr = '0; m_state = 0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        logic [PW-1:0] sum;
        exp_t e;
        m_done = 1'b0;
        m_vld  = en && !phase_clr;
        if (m_vld) begin
            sum    = m_acc + m_pow;
            m_addr = sum[PW-1:PW-AW];
        end
        if (phase_clr)  m_acc = '0;
        else if (en)    m_acc = m_acc + m_ftw;
        if (cfg_load) begin
            m_pow = cfg_pow; m_step = cfg_step; m_end = cfg_ftw_end;
            m_dir = (cfg_ftw > cfg_ftw_end);
            m_ftw = cfg_ftw;
            if (!cfg_mode) m_state = 0;
            else if (cfg_step == 0 || cfg_ftw == cfg_ftw_end) begin
                m_state = 2; m_ftw = cfg_ftw_end; m_done = 1'b1;
            end else m_state = 1;
        end else if (m_state == 1 && en && !phase_clr) begin
            if (!m_dir) begin
                if (64'(m_ftw) + 64'(m_step) >= 64'(m_end)) begin
                    m_ftw = m_end; m_state = 2; m_done = 1'b1;
                end else m_ftw = m_ftw + m_step;
            end else begin
                if (m_step >= m_ftw || (m_ftw - m_step) <= m_end) begin
                    m_ftw = m_end; m_state = 2; m_done = 1'b1;
                end else m_ftw = m_ftw - m_step;
            end
        end
        e.addr = m_addr; e.vld = m_vld; e.busy = (m_state == 1); e.done = m_done;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 64'(1), 64'(0));
        end else begin
            e = sb_q.pop_front();
            check_val("addr", 64'(addr), 64'(e.addr));
            check_val("addr_vld", 64'(addr_vld), 64'(e.vld));
            check_val("busy", 64'(busy), 64'(e.busy));
            check_val("sweep_done", 64'(sweep_done), 64'(e.done));
        end
    endtask

    task automatic drive(input logic en_v, input logic clr_v);
        en = en_v; phase_clr = clr_v; cfg_load = 1'b0;
    endtask

    task automatic load(input logic mode, input logic [PW-1:0] ftw, input logic [PW-1:0] fend,
                        input logic [PW-1:0] step, input logic [PW-1:0] pow,
                        input logic en_v, input logic clr_v);
        cfg_mode = mode; cfg_ftw = ftw; cfg_ftw_end = fend; cfg_step = step; cfg_pow = pow;
        en = en_v; phase_clr = clr_v; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        cfg_ftw = $urandom; cfg_ftw_end = $urandom; cfg_step = $urandom; cfg_pow = $urandom;
        cfg_mode = 1'($urandom);
    endtask

    initial begin
        int done_cnt;
        logic [AW-1:0] exp_off[5];
        logic [AW-1:0] exp_up[7];
        exp_off = '{12'h400, 12'h000, 12'hC00, 12'h800, 12'h400};
        exp_up  = '{12'd0, 12'd1, 12'd3, 12'd6, 12'd10, 12'd14, 12'd18};
        model_reset();
        #12;
        check_val("rst_addr", 64'(addr), 64'(0));
        check_val("rst_vld", 64'(addr_vld), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(sweep_done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // fixed mode ramp with wrap after 256 samples
        load(1'b0, 32'h0100_0000, '0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0);
        for (int k = 0; k < 260; k++) begin
            tick();
            check_val("fix_ramp", 64'(addr), 64'((k * 16) % 4096));
            check_val("fix_vld", 64'(addr_vld), 64'(1));
        end

        // offset and wrap
        load(1'b0, 32'hC000_0000, '0, '0, 32'h4000_0000, 1'b0, 1'b1);
        drive(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("off_seq", 64'(addr), 64'(exp_off[k]));
        end

        // sweep up
        load(1'b1, 32'h0010_0000, 32'h0040_0000, 32'h0010_0000, '0, 1'b0, 1'b1);
        check_val("up_busy_start", 64'(busy), 64'(1));
        drive(1'b1, 1'b0);
        done_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_val("up_addr", 64'(addr), 64'(exp_up[k]));
            check_val("up_done_edge", 64'(sweep_done), 64'(k == 2));
            check_val("up_busy_edge", 64'(busy), 64'(k < 2));
            if (sweep_done) done_cnt++;
        end
        check_val("up_done_count", 64'(done_cnt), 64'(1));

        // sweep down with clamp onto the end word
        load(1'b1, 32'h0030_0000, 32'h0005_0000, 32'h0010_0000, '0, 1'b0, 1'b1);
        drive(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("dn_done_edge", 64'(sweep_done), 64'(k == 2));
        end

        // immediate done (zero step)
        drive(1'b0, 1'b0);
        load(1'b1, 32'h0020_0000, 32'h0080_0000, '0, '0, 1'b0, 1'b0);
        check_val("imm_done", 64'(sweep_done), 64'(1));
        check_val("imm_busy", 64'(busy), 64'(0));
        tick();
        check_val("imm_done_clear", 64'(sweep_done), 64'(0));

        // load mid-sweep aborts without a done pulse; en on the load cycle uses old words
        load(1'b1, 32'h0001_0000, 32'h0100_0000, 32'h0001_0000, 32'h1234_5678, 1'b1, 1'b0);
        drive(1'b1, 1'b0);
        tick(); tick();
        load(1'b0, 32'h0200_0000, '0, '0, '0, 1'b1, 1'b0);
        check_val("abort_no_done", 64'(sweep_done), 64'(0));
        check_val("abort_busy", 64'(busy), 64'(0));
        drive(1'b1, 1'b0);
        tick(); tick();

        // phase_clr with en held
        load(1'b0, 32'h0100_0000, '0, '0, 32'h8000_0000, 1'b1, 1'b0);
        drive(1'b1, 1'b0);
        tick(); tick();
        drive(1'b1, 1'b1);
        tick();
        check_val("clr_vld", 64'(addr_vld), 64'(0));
        drive(1'b1, 1'b0);
        tick();
        check_val("clr_addr", 64'(addr), 64'(12'h800));
        check_val("clr_vld_back", 64'(addr_vld), 64'(1));

        // reset mid-sweep
        load(1'b1, 32'h0010_0000, 32'h0400_0000, 32'h0001_0000, 32'h0100_0000, 1'b1, 1'b0);
        drive(1'b1, 1'b0);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_addr", 64'(addr), 64'(0));
        check_val("mid_rst_vld", 64'(addr_vld), 64'(0));
        check_val("mid_rst_busy", 64'(busy), 64'(0));
        check_val("mid_rst_done", 64'(sweep_done), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("post_rst_addr", 64'(addr), 64'(0));
            check_val("post_rst_busy", 64'(busy), 64'(0));
        end

        check_val("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
